// File: rtl/xtea_pkg.sv
// Shared types, constants and the XTEA mixing function used by the XTEA engine.
package xtea_pkg;

    localparam logic [31:0] XTEA_DELTA = 32'h9E3779B9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [31:0] word_t;
    typedef word_t [3:0] key_t;

    function automatic word_t xtea_mix(input word_t v);
        return ((v << 4) ^ (v >> 5)) + v;
    endfunction

endpackage

// File: rtl/xtea_round.sv
// One full XTEA cycle (two Feistel half-rounds), purely combinational.
module xtea_round
    import xtea_pkg::*;
#(
    parameter word_t DELTA = XTEA_DELTA
) (
    input  word_t v0,
    input  word_t v1,
    input  word_t sum,
    input  key_t  key,
    input  logic  decrypt,
    output word_t v0_next,
    output word_t v1_next,
    output word_t sum_next
);

    // Both half-rounds chained; the second one uses the freshly updated word and sum.
    always_comb begin
        v0_next  = v0;
        v1_next  = v1;
        sum_next = sum;
        if (decrypt) begin
            v1_next  = v1 - (xtea_mix(v0) ^ (sum + key[sum[12:11]]));
            sum_next = sum - DELTA;
            v0_next  = v0 - (xtea_mix(v1_next) ^ (sum_next + key[sum_next[1:0]]));
        end else begin
            v0_next  = v0 + (xtea_mix(v1) ^ (sum + key[sum[1:0]]));
            sum_next = sum + DELTA;
            v1_next  = v1 + (xtea_mix(v0_next) ^ (sum_next + key[sum_next[12:11]]));
        end
    end

endmodule

// File: rtl/xtea_core.sv
// Iterative XTEA engine: one block in flight, one XTEA cycle per clock,
// valid/ready handshakes on both sides.
module xtea_core
    import xtea_pkg::*;
#(
    parameter int    CYCLES = 32,
    parameter word_t DELTA  = XTEA_DELTA
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] key,
    input  logic         decrypt,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_data,
    output logic         busy
);

    localparam int                CNT_W      = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0]  LAST_ROUND = CNT_W'(CYCLES - 1);
    localparam word_t             SUM_DEC    = word_t'(DELTA * CYCLES);

    state_t             state_r;
    state_t             state_next_s;
    logic               accept_s;
    logic               step_s;
    logic [CNT_W-1:0]   round_r;
    word_t              v0_r;
    word_t              v1_r;
    word_t              sum_r;
    key_t               key_r;
    logic               decrypt_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               busy_r;
    word_t              v0_nx_s;
    word_t              v1_nx_s;
    word_t              sum_nx_s;

    xtea_round #(
        .DELTA (DELTA)
    ) u_round (
        .v0       (v0_r),
        .v1       (v1_r),
        .sum      (sum_r),
        .key      (key_r),
        .decrypt  (decrypt_r),
        .v0_next  (v0_nx_s),
        .v1_next  (v1_nx_s),
        .sum_next (sum_nx_s)
    );

    // Next-state logic; acceptance also requires the registered in_ready so the
    // first cycle after reset release cannot take a block.
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        step_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready_r) begin
                    accept_s     = 1'b1;
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                step_s = 1'b1;
                if (round_r == LAST_ROUND) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register and state-derived registered handshake/status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s == IDLE);
            out_valid_r <= (state_next_s == DONE);
            busy_r      <= (state_next_s != IDLE);
        end
    end

    // Block, key and schedule registers: loaded on accept, advanced once per RUN clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v0_r      <= 32'h0000_0000;
            v1_r      <= 32'h0000_0000;
            sum_r     <= 32'h0000_0000;
            key_r     <= 128'h0;
            decrypt_r <= 1'b0;
            round_r   <= '0;
        end else if (accept_s) begin
            v0_r      <= in_data[63:32];
            v1_r      <= in_data[31:0];
            sum_r     <= decrypt ? SUM_DEC : 32'h0000_0000;
            key_r     <= key;
            decrypt_r <= decrypt;
            round_r   <= '0;
        end else if (step_s) begin
            v0_r      <= v0_nx_s;
            v1_r      <= v1_nx_s;
            sum_r     <= sum_nx_s;
            round_r   <= round_r + CNT_W'(1);
        end else begin
            v0_r      <= v0_r;
            v1_r      <= v1_r;
            sum_r     <= sum_r;
            round_r   <= round_r;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out_data  = {v0_r, v1_r};

endmodule

// File: tb/tb_xtea_core.sv
// Directed bench for xtea_core: known vector, round trip against a C-style
// reference, backpressure, input sampling, mid-run reset and streaming.
module tb_xtea_core;

    localparam logic [31:0]  DELTA = 32'h9E3779B9;
    localparam logic [127:0] RT_KEY = 128'h00112233_44556677_8899aabb_ccddeeff;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] key;
    logic         decrypt;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_data;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;
    logic         busy;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int acc_cyc;
    int lat;

    xtea_core dut (
        .clk       (clk),
        .reset     (reset),
        .key       (key),
        .decrypt   (decrypt),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // C reference: for (i<32) { v0 += ...; sum += delta; v1 += ...; } and its inverse.
    function automatic logic [63:0] ref_xtea(input logic [63:0] d, input logic [127:0] k, input logic dec);
        logic [31:0] v0, v1, sum;
        logic [31:0] kw [4];
        for (int i = 0; i < 4; i++) kw[i] = k[32*i +: 32];
        v0 = d[63:32];
        v1 = d[31:0];
        if (!dec) begin
            sum = 32'd0;
            for (int i = 0; i < 32; i++) begin
                v0 += (((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + kw[sum & 32'd3]);
                sum += DELTA;
                v1 += (((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + kw[(sum >> 11) & 32'd3]);
            end
        end else begin
            sum = DELTA * 32'd32;
            for (int i = 0; i < 32; i++) begin
                v1 -= (((v0 << 4) ^ (v0 >> 5)) + v0) ^ (sum + kw[(sum >> 11) & 32'd3]);
                sum -= DELTA;
                v0 -= (((v1 << 4) ^ (v1 >> 5)) + v1) ^ (sum + kw[sum & 32'd3]);
            end
        end
        return {v0, v1};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_accept(input logic [63:0] d, input logic [127:0] k, input logic dec);
        for (int i = 0; i < 200 && in_ready !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        chk("in_ready_wait", {63'd0, in_ready}, 64'd1);
        in_data  = d;
        key      = k;
        decrypt  = dec;
        in_valid = 1'b1;
        @(posedge clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input logic scramble, output int l);
        l = 0;
        while (out_valid !== 1'b1 && l < 200) begin
            @(posedge clk); #1;
            l++;
            if (scramble) begin
                key     = {$urandom, $urandom, $urandom, $urandom};
                in_data = {$urandom, $urandom};
                decrypt = ($urandom_range(0, 1) == 1);
            end
        end
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_ov_drop"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_in_ready_back"}, {63'd0, in_ready}, 64'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] pt, ct, first;
        logic [63:0] pts [32];
        int          prev_acc;

        reset     = 1'b1;
        key       = 128'h0;
        decrypt   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 64'h0;
        out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("idle_in_ready", {63'd0, in_ready}, 64'd1);

        // Zero encrypt known vector and its decrypt
        do_accept(64'h0, 128'h0, 1'b0);
        chk("run_busy", {63'd0, busy}, 64'd1);
        chk("run_in_ready_low", {63'd0, in_ready}, 64'd0);
        wait_out(1'b0, lat);
        chk("zero_latency", 64'(lat), 64'd32);
        chk("zero_enc", out_data, 64'hdee9d4d8_f7131ed9);
        handshake("zero_enc");
        do_accept(64'hdee9d4d8_f7131ed9, 128'h0, 1'b1);
        wait_out(1'b0, lat);
        chk("zero_dec", out_data, 64'h0);
        handshake("zero_dec");

        // Round trip with fixed key
        for (int i = 0; i < 32; i++) begin
            pt = {$urandom, $urandom};
            do_accept(pt, RT_KEY, 1'b0);
            wait_out(1'b0, lat);
            ct = out_data;
            chk("rt_enc_ref", ct, ref_xtea(pt, RT_KEY, 1'b0));
            handshake("rt_enc");
            do_accept(ct, RT_KEY, 1'b1);
            wait_out(1'b0, lat);
            chk("rt_dec_plain", out_data, pt);
            handshake("rt_dec");
        end

        // Backpressure
        pt = 64'h01234567_89abcdef;
        do_accept(pt, RT_KEY, 1'b0);
        wait_out(1'b0, lat);
        first = out_data;
        chk("bp_first", first, ref_xtea(pt, RT_KEY, 1'b0));
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            chk("bp_data_stable", out_data, first);
            chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
            chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
        end
        handshake("bp");

        // Inputs changing during RUN are ignored
        pt = 64'hfeedface_cafef00d;
        do_accept(pt, 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0, 1'b0);
        wait_out(1'b1, lat);
        chk("samp_latency", 64'(lat), 64'd32);
        chk("samp_result", out_data, ref_xtea(pt, 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0, 1'b0));
        handshake("samp");

        // Reset during RUN
        do_accept(64'h11111111_22222222, RT_KEY, 1'b0);
        repeat (10) begin @(posedge clk); #1; end
        chk("mid_busy", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        pt = 64'h33333333_44444444;
        do_accept(pt, RT_KEY, 1'b0);
        wait_out(1'b0, lat);
        chk("post_rst_latency", 64'(lat), 64'd32);
        chk("post_rst_result", out_data, ref_xtea(pt, RT_KEY, 1'b0));
        handshake("post_rst");

        // Streaming with out_ready tied high
        out_ready = 1'b1;
        prev_acc  = 0;
        for (int i = 0; i < 32; i++) begin
            pts[i] = {$urandom, $urandom};
            do_accept(pts[i], RT_KEY, 1'b0);
            if (i > 0) chk("stream_spacing", 64'(acc_cyc - prev_acc), 64'd34);
            prev_acc = acc_cyc;
            wait_out(1'b0, lat);
            chk("stream_result", out_data, ref_xtea(pts[i], RT_KEY, 1'b0));
        end
        @(posedge clk); #1;
        chk("stream_end_ov", {63'd0, out_valid}, 64'd0);
        out_ready = 1'b0;

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/xtea_core.md
# xtea_core

Iterative XTEA block-cipher engine that transforms 64-bit blocks under a 128-bit key, encrypting or decrypting. It sits directly downstream of the DMA read path inside `avalon_accel`. The DMA packs two consecutive 32-bit SRAM words into one block, hands it over with a valid/ready handshake, and collects the result for write-back to the destination address. Key words come straight from the K0–K3 configuration registers.

## Interface
Parameters:
- `CYCLES`, 32: number of XTEA cycles (each cycle is two Feistel half-rounds); legal range 1–32.
- `DELTA`, 32'h9E3779B9: key-schedule constant.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `key` in 128: key; `key[32*i +: 32]` = K*i* register (i = 0..3); sampled on input accept.
- `decrypt` in 1: 0 = encrypt, 1 = decrypt; sampled on input accept.
- `in_valid` in 1: input block valid.
- `in_ready` out 1: core can accept a block.
- `in_data` in 64: `{v0, v1}`; v0 = `[63:32]` (first SRAM word), v1 = `[31:0]`.
- `out_valid` out 1: result valid; held until consumed.
- `out_ready` in 1: consumer accepts the result.
- `out_data` out 64: `{v0, v1}` result.
- `busy` out 1: high in RUN or DONE.

## Operation
- FSM states are IDLE, RUN and DONE. Reset enters IDLE.
- **IDLE:** `in_ready` = 1. When `in_valid` is high:
  - latch `in_data`, `key` and `decrypt`;
  - set round counter = 0;
  - set sum = 0 for encrypt, or `DELTA*CYCLES` mod 2^32 for decrypt (32'hC6EF3720 at the defaults);
  - go to RUN.
- **RUN:** one full cycle per clock. All arithmetic is mod 2^32, shifts are logical, and k[j] is the latched key word j.
  - Encrypt: v0 += (((v1<<4) ^ (v1>>5)) + v1) ^ (sum + k[sum[1:0]]); then sum' = sum + DELTA; then v1 += (((v0'<<4) ^ (v0'>>5)) + v0') ^ (sum' + k[sum'[12:11]]). Here v0' is the updated v0.
  - Decrypt: v1 -= (((v0<<4) ^ (v0>>5)) + v0) ^ (sum + k[sum[12:11]]); then sum' = sum − DELTA; then v0 -= (((v1'<<4) ^ (v1'>>5)) + v1') ^ (sum' + k[sum'[1:0]]).
  - Both half-rounds are combinational within one clock.
  - After the round with counter = CYCLES−1, go to DONE.
- **DONE:** `out_valid` = 1 and `out_data` = {v0, v1}, stable until `out_ready`. On `out_valid && out_ready`, go to IDLE.
- Key, `decrypt` and `in_data` changes during RUN or DONE are ignored.
- No pipelining: at most one block in flight.

## Timing
- Reset values: `in_ready` = 0 while `reset` is asserted and 1 once in IDLE; `out_valid` = 0; `out_data` = 0; `busy` = 0. The internal v0, v1, sum and counter are 0.
- Accept at edge T (in_valid && in_ready) → `out_valid` rises after edge T+CYCLES. Latency is 32 clocks at the default.
- `in_ready` is low from the cycle after accept until the cycle after the output handshake.
- Throughput: one block per CYCLES+2 clocks when `out_ready` is held high.
- `in_ready` is registered, derived from state only. It never depends combinationally on `in_valid` or `out_ready`.
- `out_data` comes straight from registers, with no combinational path from inputs.
- Backpressure: `out_ready` low in DONE holds state indefinitely with `out_data` unchanged.
- Reset mid-RUN or mid-DONE returns to IDLE immediately. The block in flight is discarded, and `out_valid` drops asynchronously.
- `in_valid` asserted in the same cycle as the output handshake is not accepted; it is accepted on the next cycle, in IDLE.

## Structure
- Package `xtea_pkg` holds:
  - the `DELTA` default;
  - the state enum `{IDLE, RUN, DONE}`;
  - `typedef logic [31:0] word_t`;
  - `typedef word_t [3:0] key_t`;
  - function `xtea_mix(word_t v)`, returning ((v<<4) ^ (v>>5)) + v.
- Sub-module `xtea_round`: purely combinational; inputs v0, v1, sum, key and decrypt; outputs next v0, v1 and sum. It is instantiated once, and the top holds the FSM, counter and registers.

## Test plan
- **Zero encrypt:** key = 0, in_data = 0, decrypt = 0 → out_data = 64'hdee9d4d8_f7131ed9; `out_valid` rises exactly 32 clocks after accept.
- **Round trip:** key = {32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff} ([127:96]..[31:0]), 32 random blocks encrypted, then fed back with decrypt = 1 → every output equals the original plaintext, and every ciphertext matches the C reference model.
- **Backpressure:** `out_ready` held low 50 clocks after `out_valid` → `out_data` stable, `in_ready` = 0 throughout; then `out_ready` = 1 → handshake in one cycle, `in_ready` = 1 on the next cycle.
- **Input sampling:** `key` and `in_data` changed every cycle during RUN → result equals the value computed from the accept-time inputs.
- **Reset mid-operation:** reset asserted at round 10 → `out_valid` = 0 and `busy` = 0 immediately; a fresh block after release gives the correct result with 32-clock latency.
- **Streaming:** 64 SRAM words (32 blocks) with `out_ready` tied high → 32 results in order; accept-to-accept spacing is 34 clocks.
